load_align_unit: RTL and testbench
==================================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, legal values 32 or 64: bus and register width.
REQ-002 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 Parameter MISALIGN_EN, default 1: 1 = split misaligned loads into two bus beats; 0 = report them as misaligned.
REQ-004 Port i_clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port i_arst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Ports i_req_valid in 1, o_req_ready out 1, i_func_3 in 3, i_addr in ADDR_WIDTH: load request from the core.
REQ-007 Ports o_mem_valid out 1, i_mem_ready in 1, o_mem_addr out ADDR_WIDTH (DATA_WIDTH/8-aligned): memory read request.
REQ-008 Ports i_mem_rvalid in 1, i_mem_rdata in DATA_WIDTH: memory read data, one beat per accepted request, in order.
REQ-009 Ports o_rsp_valid out 1, i_rsp_ready in 1, o_rsp_data out DATA_WIDTH, o_load_addr_ma out 1, o_illegal_instr out 1: load result to the core.

Function
REQ-010 A transfer on any channel SHALL occur only in a cycle where valid and ready are both high; o_mem_valid and o_rsp_valid, once high, SHALL stay high with stable payload until accepted.
REQ-011 FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; o_req_ready SHALL be high only in IDLE.
REQ-012 IDLE: on request accept, the unit SHALL latch func_3, address and offset, then go to RESP if the op is illegal or misaligned-with-MISALIGN_EN=0, else to REQ0.
REQ-013 Legal func_3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU are legal only when DATA_WIDTH=64; all others SHALL give o_illegal_instr=1, o_rsp_data=0.
REQ-014 Misaligned means address not a multiple of the access size (1/2/4/8 bytes); with MISALIGN_EN=0 the response SHALL carry o_load_addr_ma=1, o_rsp_data=0, and no memory request is issued.
REQ-015 REQ0 SHALL present the aligned address of the first byte; REQ0->WAIT0 on accept; WAIT0 captures the beat on i_mem_rvalid.
REQ-016 If the access crosses a DATA_WIDTH/8 boundary, WAIT0 SHALL go to REQ1 (next aligned address, wrap-around modulo 2^ADDR_WIDTH), REQ1->WAIT1 on accept, WAIT1 captures beat 1; otherwise WAIT0 goes to RESP.
REQ-017 Data SHALL be extracted from {beat1, beat0} shifted right by offset bytes, then sign-extended (LB, LH, LW on 64-bit) or zero-extended (LBU, LHU, LWU); LW on 32-bit and LD pass through.
REQ-018 RESP: o_rsp_valid=1; on i_rsp_ready the FSM SHALL return to IDLE; next request is accepted no earlier than the following cycle.
REQ-019 Latency: aligned load with zero-wait memory (ready high, rvalid the cycle after accept) SHALL give o_rsp_valid 3 cycles after request accept; split load 5 cycles.
REQ-020 o_load_addr_ma and o_illegal_instr SHALL be zero whenever o_rsp_valid is zero.
REQ-021 i_mem_rvalid outside WAIT0/WAIT1 SHALL be ignored.

Reset
REQ-022 Assertion of i_arst_n low SHALL immediately force state IDLE, o_mem_valid=0, o_rsp_valid=0, o_rsp_data=0, o_load_addr_ma=0, o_illegal_instr=0, o_mem_addr=0; o_req_ready follows state and is high during reset.
REQ-023 Reset mid-operation SHALL abandon the load without a response; the memory side is reset by the same signal.

Structure
REQ-024 Shared package SHALL hold the func_3 load-encoding constants and the FSM state enum.
REQ-025 Combinational extraction/extension (REQ-017) SHALL be a sub-module load_extract, parametrised by DATA_WIDTH.

Verification
REQ-026 DW=32, LB addr 0x103, rdata 0x80FF_0000 -> o_rsp_data 0xFFFF_FF80, one memory beat at 0x100.
REQ-027 DW=32, MISALIGN_EN=1, LW addr 0x0FE, beats 0xAABB_CCDD@0x0FC, 0x1122_3344@0x100 -> 0x3344_AABB, two beats.
REQ-028 DW=32, MISALIGN_EN=0, LH addr 0x001 -> o_load_addr_ma=1, data 0, no o_mem_valid.
REQ-029 DW=32, func_3=011 -> o_illegal_instr=1; DW=64 LWU addr 0x4, rdata 0x8000_0001_0000_0000 -> 0x0000_0000_8000_0001.
REQ-030 i_rsp_ready held low 4 cycles -> response held stable, o_req_ready low; i_arst_n pulse in WAIT1 -> IDLE, no response.

Source files
------------

// File: rtl/load_align_unit_pkg.sv
// Shared load-unit definitions: func_3 load encodings, FSM state enum and op decode helpers.
package load_align_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } state_e;

    // Access size in bytes, encoded by the low two func_3 bits.
    function automatic logic [3:0] access_size(input logic [2:0] f3);
        logic [3:0] size;
        case (f3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3, input int unsigned dw);
        logic legal;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
            F3_LD, F3_LWU:                       legal = (dw == 64);
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Core request, memory read and response channels of the load align unit.
interface load_align_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [2:0]            i_func_3;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  o_mem_valid;
    logic                  i_mem_ready;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  i_mem_rvalid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_load_addr_ma;
    logic                  o_illegal_instr;

    modport slave (
        input  i_req_valid, i_func_3, i_addr, i_mem_ready, i_mem_rvalid, i_mem_rdata, i_rsp_ready,
        output o_req_ready, o_mem_valid, o_mem_addr, o_rsp_valid, o_rsp_data, o_load_addr_ma,
               o_illegal_instr
    );

    modport master (
        output i_req_valid, i_func_3, i_addr, i_mem_ready, i_mem_rvalid, i_mem_rdata, i_rsp_ready,
        input  o_req_ready, o_mem_valid, o_mem_addr, o_rsp_valid, o_rsp_data, o_load_addr_ma,
               o_illegal_instr
    );
endinterface

// File: rtl/load_extract.sv
// Byte-shifts the two-beat window by the load offset and sign/zero-extends per func_3.
module load_extract
    import load_align_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0]         i_beats,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] i_offset,
    input  logic [2:0]                      i_func_3,
    output logic [DATA_WIDTH-1:0]           o_data_c
);
    logic [DATA_WIDTH-1:0] shifted_c;

    assign shifted_c = DATA_WIDTH'(i_beats >> {i_offset, 3'b000});

    always_comb begin
        o_data_c = '0;
        case (i_func_3)
            F3_LB:   o_data_c = DATA_WIDTH'($signed(shifted_c[7:0]));
            F3_LH:   o_data_c = DATA_WIDTH'($signed(shifted_c[15:0]));
            F3_LW:   o_data_c = DATA_WIDTH'($signed(shifted_c[31:0]));
            F3_LBU:  o_data_c = DATA_WIDTH'(shifted_c[7:0]);
            F3_LHU:  o_data_c = DATA_WIDTH'(shifted_c[15:0]);
            F3_LWU:  o_data_c = DATA_WIDTH'(shifted_c[31:0]);
            F3_LD:   o_data_c = shifted_c;
            default: o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load align unit: accepts a core load, issues one or two aligned memory beats,
// and returns the extracted, extended result (or a misaligned/illegal flag).
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    load_align_unit_if.slave bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);

    state_e                state_q, state_d;
    logic [2:0]            func3_q, func3_d;
    logic [OFFW-1:0]       off_q, off_d;
    logic [DATA_WIDTH-1:0] beat0_q, beat0_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  ma_q, ma_d;
    logic                  ill_q, ill_d;

    logic [3:0]              req_mask_c;
    logic                    req_legal_c;
    logic                    req_misal_c;
    logic [4:0]              end_c;
    logic                    cross_c;
    logic [2*DATA_WIDTH-1:0] beats_c;
    logic [DATA_WIDTH-1:0]   ext_data_c;

    assign req_mask_c  = access_size(bus.i_func_3) - 4'd1;
    assign req_legal_c = f3_legal(bus.i_func_3, DATA_WIDTH);
    assign req_misal_c = |(bus.i_addr[3:0] & req_mask_c);

    // Access spills into the next bus word when its last byte lies past this one.
    assign end_c   = 5'(off_q) + 5'(access_size(func3_q));
    assign cross_c = end_c > 5'(BYTES);

    assign beats_c = (state_q == ST_WAIT1) ? {bus.i_mem_rdata, beat0_q}
                                           : {{DATA_WIDTH{1'b0}}, bus.i_mem_rdata};

    load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
        .i_beats  (beats_c),
        .i_offset (off_q),
        .i_func_3 (func3_q),
        .o_data_c (ext_data_c)
    );

    always_comb begin
        state_d     = state_q;
        func3_d     = func3_q;
        off_d       = off_q;
        beat0_d     = beat0_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        ma_d        = ma_q;
        ill_d       = ill_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_valid && req_ready_q) begin
                    func3_d    = bus.i_func_3;
                    off_d      = bus.i_addr[OFFW-1:0];
                    mem_addr_d = {bus.i_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                    if (!req_legal_c) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        ill_d       = 1'b1;
                    end else if (req_misal_c && !MISALIGN_EN) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        ma_d        = 1'b1;
                    end else begin
                        state_d     = ST_REQ0;
                        mem_valid_d = 1'b1;
                    end
                end
            end
            ST_REQ0: begin
                if (bus.i_mem_ready) begin
                    state_d     = ST_WAIT0;
                    mem_valid_d = 1'b0;
                end
            end
            ST_WAIT0: begin
                if (bus.i_mem_rvalid) begin
                    if (cross_c) begin
                        state_d     = ST_REQ1;
                        beat0_d     = bus.i_mem_rdata;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(BYTES);
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = ext_data_c;
                    end
                end
            end
            ST_REQ1: begin
                if (bus.i_mem_ready) begin
                    state_d     = ST_WAIT1;
                    mem_valid_d = 1'b0;
                end
            end
            ST_WAIT1: begin
                if (bus.i_mem_rvalid) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ext_data_c;
                end
            end
            ST_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    ma_d        = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= ST_IDLE;
            func3_q     <= '0;
            off_q       <= '0;
            beat0_q     <= '0;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ma_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            beat0_q     <= beat0_d;
            req_ready_q <= req_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ma_q        <= ma_d;
            ill_q       <= ill_d;
        end
    end

    assign bus.o_req_ready     = req_ready_q;
    assign bus.o_mem_valid     = mem_valid_q;
    assign bus.o_mem_addr      = mem_addr_q;
    assign bus.o_rsp_valid     = rsp_valid_q;
    assign bus.o_rsp_data      = rsp_data_q;
    assign bus.o_load_addr_ma  = ma_q;
    assign bus.o_illegal_instr = ill_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: three instances (32-bit split, 32-bit no-split, 64-bit).
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic        ma;
        logic        ill;
        logic [1:0]  beats;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  lat;
    } res_t;

    typedef struct {
        int          sel;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [63:0] d0;
        logic [63:0] d1;
        res_t        e;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic        req_valid  [3];
    logic [2:0]  func3      [3];
    logic [31:0] addr       [3];
    logic        mem_rvalid [3];
    logic [63:0] mem_rdata  [3];
    logic        rsp_ready  [3];
    logic        req_ready_o[3];
    logic        mem_valid_o[3];
    logic [31:0] mem_addr_o [3];
    logic        rsp_valid_o[3];
    logic [63:0] rsp_data_o [3];
    logic        ma_o       [3];
    logic        ill_o      [3];

    always #5 clk = ~clk;

    load_align_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    load_align_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
    load_align_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus2 ();

    load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGN_EN(1'b1)) u_dut0 (
        .i_clk(clk), .i_arst_n(rst_n), .bus(bus0));
    load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGN_EN(1'b0)) u_dut1 (
        .i_clk(clk), .i_arst_n(rst_n), .bus(bus1));
    load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MISALIGN_EN(1'b1)) u_dut2 (
        .i_clk(clk), .i_arst_n(rst_n), .bus(bus2));

    assign bus0.i_req_valid = req_valid[0];  assign bus0.i_func_3 = func3[0];
    assign bus0.i_addr = addr[0];            assign bus0.i_mem_ready = 1'b1;
    assign bus0.i_mem_rvalid = mem_rvalid[0]; assign bus0.i_mem_rdata = mem_rdata[0][31:0];
    assign bus0.i_rsp_ready = rsp_ready[0];
    assign req_ready_o[0] = bus0.o_req_ready; assign mem_valid_o[0] = bus0.o_mem_valid;
    assign mem_addr_o[0] = bus0.o_mem_addr;   assign rsp_valid_o[0] = bus0.o_rsp_valid;
    assign rsp_data_o[0] = {32'h0, bus0.o_rsp_data};
    assign ma_o[0] = bus0.o_load_addr_ma;     assign ill_o[0] = bus0.o_illegal_instr;

    assign bus1.i_req_valid = req_valid[1];  assign bus1.i_func_3 = func3[1];
    assign bus1.i_addr = addr[1];            assign bus1.i_mem_ready = 1'b1;
    assign bus1.i_mem_rvalid = mem_rvalid[1]; assign bus1.i_mem_rdata = mem_rdata[1][31:0];
    assign bus1.i_rsp_ready = rsp_ready[1];
    assign req_ready_o[1] = bus1.o_req_ready; assign mem_valid_o[1] = bus1.o_mem_valid;
    assign mem_addr_o[1] = bus1.o_mem_addr;   assign rsp_valid_o[1] = bus1.o_rsp_valid;
    assign rsp_data_o[1] = {32'h0, bus1.o_rsp_data};
    assign ma_o[1] = bus1.o_load_addr_ma;     assign ill_o[1] = bus1.o_illegal_instr;

    assign bus2.i_req_valid = req_valid[2];  assign bus2.i_func_3 = func3[2];
    assign bus2.i_addr = addr[2];            assign bus2.i_mem_ready = 1'b1;
    assign bus2.i_mem_rvalid = mem_rvalid[2]; assign bus2.i_mem_rdata = mem_rdata[2];
    assign bus2.i_rsp_ready = rsp_ready[2];
    assign req_ready_o[2] = bus2.o_req_ready; assign mem_valid_o[2] = bus2.o_mem_valid;
    assign mem_addr_o[2] = bus2.o_mem_addr;   assign rsp_valid_o[2] = bus2.o_rsp_valid;
    assign rsp_data_o[2] = bus2.o_rsp_data;
    assign ma_o[2] = bus2.o_load_addr_ma;     assign ill_o[2] = bus2.o_illegal_instr;

    function automatic res_t mk(input logic [63:0] d, input logic ma, input logic ill,
                                input int b, input logic [31:0] a0, input logic [31:0] a1,
                                input int lat);
        res_t r;
        r.data = d; r.ma = ma; r.ill = ill; r.beats = 2'(b);
        r.a0 = a0; r.a1 = a1; r.lat = 4'(lat);
        return r;
    endfunction

    // One load with a zero-wait memory model; optional response backpressure for 'hold' cycles.
    task automatic do_load(input int sel, input logic [2:0] f3, input logic [31:0] a,
                           input logic [63:0] d0, input logic [63:0] d1, input int hold,
                           output res_t r);
        int nbeats;
        int pidx;
        bit pend;
        r = '0; nbeats = 0; pidx = 0; pend = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready_o[sel] !== 1'b1) begin
            errors++; $display("FAIL req_ready_idle[%0d]: got %b required 1", sel, req_ready_o[sel]);
        end
        req_valid[sel] = 1'b1; func3[sel] = f3; addr[sel] = a; rsp_ready[sel] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[sel] = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            mem_rvalid[sel] = pend;
            mem_rdata[sel]  = pend ? ((pidx == 0) ? d0 : d1) : 64'h0;
            pend = 1'b0;
            if (mem_valid_o[sel] === 1'b1) begin
                if (nbeats == 0) r.a0 = mem_addr_o[sel]; else r.a1 = mem_addr_o[sel];
                pidx = nbeats; nbeats++; pend = 1'b1;
            end
            if (rsp_valid_o[sel] === 1'b1) begin
                r.lat = 4'(c); r.data = rsp_data_o[sel]; r.ma = ma_o[sel]; r.ill = ill_o[sel];
                break;
            end
        end
        mem_rvalid[sel] = 1'b0;
        r.beats = 2'(nbeats);
        if (r.lat == 4'd0) begin
            checks++; errors++; $display("FAIL rsp_timeout[%0d]: got none required o_rsp_valid", sel);
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_o[sel] !== 1'b1 || rsp_data_o[sel] !== r.data ||
                req_ready_o[sel] !== 1'b0 || ma_o[sel] !== r.ma || ill_o[sel] !== r.ill) begin
                errors++;
                $display("FAIL rsp_hold[%0d] cycle %0d: got v=%b d=%h rdy=%b required v=1 d=%h rdy=0",
                         sel, h, rsp_valid_o[sel], rsp_data_o[sel], req_ready_o[sel], r.data);
            end
        end
        rsp_ready[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[sel] = 1'b0;
        checks++;
        if ({rsp_valid_o[sel], ma_o[sel], ill_o[sel], req_ready_o[sel]} !== 4'b0001) begin
            errors++;
            $display("FAIL rsp_release[%0d]: got v/ma/ill/rdy=%b%b%b%b required 0001", sel,
                     rsp_valid_o[sel], ma_o[sel], ill_o[sel], req_ready_o[sel]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({req_ready_o[s], mem_valid_o[s], rsp_valid_o[s], ma_o[s], ill_o[s]} !== 5'b10000 ||
                rsp_data_o[s] !== 64'h0 || mem_addr_o[s] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got rdy/mv/rv/ma/ill=%b%b%b%b%b d=%h a=%h required 10000 0 0",
                         s, req_ready_o[s], mem_valid_o[s], rsp_valid_o[s], ma_o[s], ill_o[s],
                         rsp_data_o[s], mem_addr_o[s]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        vec_t v[4];
        res_t r;
        v[0] = '{0, F3_LB,  32'h103, 64'h80FF_0000, 64'h0, mk(64'hFFFF_FF80, 0, 0, 1, 32'h100, 0, 3), "lb_off3"};
        v[1] = '{0, F3_LW,  32'h200, 64'hDEAD_BEEF, 64'h0, mk(64'hDEAD_BEEF, 0, 0, 1, 32'h200, 0, 3), "lw_aligned"};
        v[2] = '{0, F3_LHU, 32'h102, 64'h8001_0000, 64'h0, mk(64'h0000_8001, 0, 0, 1, 32'h100, 0, 3), "lhu_off2"};
        v[3] = '{0, F3_LH,  32'h001, 64'h00C0_FF00, 64'h0, mk(64'hFFFF_C0FF, 0, 0, 1, 32'h000, 0, 3), "lh_misal_inword"};
        foreach (v[i]) begin
            do_load(v[i].sel, v[i].f3, v[i].a, v[i].d0, v[i].d1, 0, r);
            checks++;
            if (r !== v[i].e) begin errors++; $display("FAIL %s: got %h required %h", v[i].name, r, v[i].e); end
        end
    endtask

    task automatic test_split();
        vec_t v[3];
        res_t r;
        v[0] = '{0, F3_LW,  32'h0FE, 64'hAABB_CCDD, 64'h1122_3344,
                 mk(64'h3344_AABB, 0, 0, 2, 32'h0FC, 32'h100, 5), "lw_split"};
        v[1] = '{0, F3_LHU, 32'h0FF, 64'h1234_5678, 64'hCAFE_BABE,
                 mk(64'h0000_BE12, 0, 0, 2, 32'h0FC, 32'h100, 5), "lhu_split"};
        v[2] = '{0, F3_LH,  32'hFFFF_FFFF, 64'h7F00_0000, 64'h0000_0080,
                 mk(64'hFFFF_807F, 0, 0, 2, 32'hFFFF_FFFC, 32'h0, 5), "lh_split_wrap"};
        foreach (v[i]) begin
            do_load(v[i].sel, v[i].f3, v[i].a, v[i].d0, v[i].d1, 0, r);
            checks++;
            if (r !== v[i].e) begin errors++; $display("FAIL %s: got %h required %h", v[i].name, r, v[i].e); end
        end
    endtask

    task automatic test_misalign_disabled();
        vec_t v[3];
        res_t r;
        v[0] = '{1, F3_LH, 32'h001, 64'h1111_1111, 64'h0, mk(64'h0, 1, 0, 0, 0, 0, 1), "ma_lh"};
        v[1] = '{1, F3_LW, 32'h102, 64'h2222_2222, 64'h0, mk(64'h0, 1, 0, 0, 0, 0, 1), "ma_lw"};
        v[2] = '{1, F3_LW, 32'h104, 64'h0102_0304, 64'h0, mk(64'h0102_0304, 0, 0, 1, 32'h104, 0, 3), "ma_off_aligned_lw"};
        foreach (v[i]) begin
            do_load(v[i].sel, v[i].f3, v[i].a, v[i].d0, v[i].d1, 0, r);
            checks++;
            if (r !== v[i].e) begin errors++; $display("FAIL %s: got %h required %h", v[i].name, r, v[i].e); end
        end
    endtask

    task automatic test_illegal();
        vec_t v[4];
        res_t r;
        v[0] = '{0, 3'b011, 32'h100, 64'h5555_5555, 64'h0, mk(64'h0, 0, 1, 0, 0, 0, 1), "ill_ld_dw32"};
        v[1] = '{0, 3'b111, 32'h100, 64'h5555_5555, 64'h0, mk(64'h0, 0, 1, 0, 0, 0, 1), "ill_111_dw32"};
        v[2] = '{1, 3'b110, 32'h000, 64'h5555_5555, 64'h0, mk(64'h0, 0, 1, 0, 0, 0, 1), "ill_lwu_dw32"};
        v[3] = '{2, 3'b111, 32'h008, 64'h5555_5555, 64'h0, mk(64'h0, 0, 1, 0, 0, 0, 1), "ill_111_dw64"};
        foreach (v[i]) begin
            do_load(v[i].sel, v[i].f3, v[i].a, v[i].d0, v[i].d1, 0, r);
            checks++;
            if (r !== v[i].e) begin errors++; $display("FAIL %s: got %h required %h", v[i].name, r, v[i].e); end
        end
    endtask

    task automatic test_dw64();
        vec_t v[4];
        res_t r;
        v[0] = '{2, F3_LWU, 32'h004, 64'h8000_0001_0000_0000, 64'h0,
                 mk(64'h0000_0000_8000_0001, 0, 0, 1, 32'h0, 0, 3), "lwu64"};
        v[1] = '{2, F3_LW,  32'h004, 64'h8000_0001_0000_0000, 64'h0,
                 mk(64'hFFFF_FFFF_8000_0001, 0, 0, 1, 32'h0, 0, 3), "lw64_sext"};
        v[2] = '{2, F3_LD,  32'h008, 64'h0123_4567_89AB_CDEF, 64'h0,
                 mk(64'h0123_4567_89AB_CDEF, 0, 0, 1, 32'h8, 0, 3), "ld_aligned"};
        v[3] = '{2, F3_LD,  32'h00C, 64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444,
                 mk(64'h4444_4444_1111_1111, 0, 0, 2, 32'h8, 32'h10, 5), "ld_split"};
        foreach (v[i]) begin
            do_load(v[i].sel, v[i].f3, v[i].a, v[i].d0, v[i].d1, 0, r);
            checks++;
            if (r !== v[i].e) begin errors++; $display("FAIL %s: got %h required %h", v[i].name, r, v[i].e); end
        end
    endtask

    task automatic test_backpressure();
        res_t r;
        res_t e;
        e = mk(64'hFFFF_FFAB, 0, 0, 1, 32'h100, 0, 3);
        do_load(0, F3_LB, 32'h100, 64'h0000_00AB, 64'h0, 4, r);
        checks++;
        if (r !== e) begin errors++; $display("FAIL backpressure_lb: got %h required %h", r, e); end
    endtask

    task automatic test_reset_mid();
        res_t r;
        res_t e;
        @(negedge clk);
        req_valid[0] = 1'b1; func3[0] = F3_LW; addr[0] = 32'h0FE; rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        mem_rvalid[0] = 1'b1; mem_rdata[0] = 64'hAABB_CCDD;
        @(negedge clk);
        mem_rvalid[0] = 1'b0;
        checks++;
        if (mem_valid_o[0] !== 1'b1 || mem_addr_o[0] !== 32'h100) begin
            errors++; $display("FAIL reset_mid_req1: got v=%b a=%h required v=1 a=00000100",
                               mem_valid_o[0], mem_addr_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready_o[0], mem_valid_o[0], rsp_valid_o[0]} !== 3'b100 || mem_addr_o[0] !== 32'h0) begin
            errors++; $display("FAIL reset_async: got rdy/mv/rv=%b%b%b a=%h required 100 a=0",
                               req_ready_o[0], mem_valid_o[0], rsp_valid_o[0], mem_addr_o[0]);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid[0] = (i == 0); mem_rdata[0] = 64'h1122_3344;
            checks++;
            if ({req_ready_o[0], mem_valid_o[0], rsp_valid_o[0]} !== 3'b100) begin
                errors++; $display("FAIL reset_no_rsp cycle %0d: got rdy/mv/rv=%b%b%b required 100",
                                   i, req_ready_o[0], mem_valid_o[0], rsp_valid_o[0]);
            end
        end
        mem_rvalid[0] = 1'b0;
        rsp_ready[0]  = 1'b0;
        e = mk(64'h3344_AABB, 0, 0, 2, 32'h0FC, 32'h100, 5);
        do_load(0, F3_LW, 32'h0FE, 64'hAABB_CCDD, 64'h1122_3344, 0, r);
        checks++;
        if (r !== e) begin errors++; $display("FAIL after_reset_lw: got %h required %h", r, e); end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            req_valid[s] = 1'b0; func3[s] = 3'b000; addr[s] = 32'h0;
            mem_rvalid[s] = 1'b0; mem_rdata[s] = 64'h0; rsp_ready[s] = 1'b0;
        end
        test_reset();
        test_aligned();
        test_split();
        test_misalign_disabled();
        test_illegal();
        test_dw64();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1);
    end

endmodule
